// File: rtl/a0_uart_tx.sv
// a0_uart_tx: sends each new value of the CPU a0 register as four UART bytes, MSB first.
// Define A0_UART_TX_PARITY_EN to add an even parity bit to every byte (11-bit frames).
module a0_uart_tx #(
    parameter int WIDTH        = 32,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a0_in,
    output logic             tx,
    output logic             busy,
    output logic             overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef A0_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

`ifdef A0_UART_TX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    count_q, count_d;
    logic             tx_q, tx_d, busy_q, busy_d, ovf_q, ovf_d;
    logic             push, pop, full, accept, wrap;
    logic [7:0]       cur_byte;

    assign push   = a0_in != prev_q;
    assign full   = count_q == CW'(FIFO_DEPTH);
    assign accept = push && (!full || pop);

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        pop     = 1'b0;
        wrap    = cnt_q == 16'(CLKS_PER_BIT - 1);
        cnt_d   = (state_q == IDLE || wrap) ? 16'd0 : cnt_q + 16'd1;
        case (state_q)
            IDLE: if (count_q != '0) begin
                pop     = 1'b1;
                shift_d = mem[rd_q];
                byte_d  = 2'd0;
                state_d = START;
            end
            START: if (wrap) begin
                bit_d   = 3'd0;
                state_d = DATA;
            end
            DATA: if (wrap) begin
                bit_d   = bit_q + 3'd1;
                state_d = (bit_q == 3'd7) ? AFTER_DATA : DATA;
            end
`ifdef A0_UART_TX_PARITY_EN
            PARITY: if (wrap) state_d = STOP;
`endif
            STOP: if (wrap) begin
                byte_d  = (byte_q == 2'd3) ? byte_q : byte_q + 2'd1;
                state_d = (byte_q == 2'd3) ? IDLE : START;
            end
            default: state_d = IDLE;
        endcase
        // tx is registered from the next state so the line never glitches
        cur_byte = shift_d[{~byte_d, 3'b000} +: 8];
        tx_d     = (state_d == START) ? 1'b0 : (state_d == DATA) ? cur_byte[bit_d] : 1'b1;
`ifdef A0_UART_TX_PARITY_EN
        if (state_d == PARITY) tx_d = ^cur_byte;
`endif
        count_d = count_q + CW'(accept) - CW'(pop);
        ovf_d   = ovf_q | (push & full & ~pop);
        busy_d  = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            prev_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            prev_q  <= a0_in;
            wr_q    <= accept ? wr_q + AW'(1) : wr_q;
            rd_q    <= pop ? rd_q + AW'(1) : rd_q;
            count_q <= count_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_q] <= a0_in;
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_a0_uart_tx.sv
// tb_a0_uart_tx: randomized and directed bench for a0_uart_tx with a queue-based frame model.
module tb_a0_uart_tx;
    localparam int C     = 4;
    localparam int DEPTH = 4;
`ifdef A0_UART_TX_PARITY_EN
    localparam int FR = 11;
`else
    localparam int FR = 10;
`endif
    localparam int WORD_CYC = 4 * FR * C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a0_in = '0;
    logic        tx, busy, overflow;

    int errors = 0;
    int checks = 0;

    logic [31:0] fifo [$];
    logic        frame [$];
    logic        rec [$];
    logic [31:0] prev = '0;
    logic        m_tx = 1'b1, m_busy = 1'b0, m_ovf = 1'b0, m_idle = 1'b1;

    a0_uart_tx #(.WIDTH(32), .CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .a0_in(a0_in), .tx(tx), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fifo.delete();
        frame.delete();
        prev   = '0;
        m_tx   = 1'b1;
        m_busy = 1'b0;
        m_ovf  = 1'b0;
        m_idle = 1'b1;
    endtask

    // A word becomes its full list of line levels, one entry per clock.
    task automatic build_frame(input logic [31:0] w);
        logic [7:0] by;
        for (int b = 0; b < 4; b++) begin
            by = w[31 - 8 * b -: 8];
            repeat (C) frame.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (C) frame.push_back(by[i]);
`ifdef A0_UART_TX_PARITY_EN
            repeat (C) frame.push_back(^by);
`endif
            repeat (C) frame.push_back(1'b1);
        end
    endtask

    task automatic model_step();
        logic        push, full, pop;
        logic [31:0] w;
        if (!rst) begin
            model_reset();
            return;
        end
        push = a0_in != prev;
        prev = a0_in;
        full = fifo.size() == DEPTH;
        pop  = m_idle && fifo.size() != 0;
        if (pop) begin
            w = fifo.pop_front();
            build_frame(w);
        end
        if (push && (!full || pop)) fifo.push_back(a0_in);
        else if (push) m_ovf = 1'b1;
        if (frame.size() != 0) begin
            m_tx   = frame.pop_front();
            m_idle = 1'b0;
        end else begin
            m_tx   = 1'b1;
            m_idle = 1'b1;
        end
        m_busy = !m_idle || fifo.size() != 0;
    endtask

    task automatic tick(input logic [31:0] v);
        a0_in = v;
        @(posedge clk);
        model_step();
        #1;
        chk("tx", tx, m_tx);
        chk("busy", busy, m_busy);
        chk("overflow", overflow, m_ovf);
        rec.push_back(tx);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick(a0_in);
            n++;
        end
        chk("drain_done", busy, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        tick(a0_in);
        tick(a0_in);
        rst = 1'b1;
        rec.delete();
    endtask

    // Reads word k of a back-to-back burst from the recorded line, sampling mid-bit.
    function automatic logic [31:0] decode(input int k);
        int          s = -1;
        int          idx;
        logic [31:0] w = 'x;
        for (int i = 0; i < rec.size(); i++) if (s < 0 && rec[i] == 1'b0) s = i;
        if (s < 0) return 'x;
        s = s + k * (WORD_CYC + 1);
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 8; i++) begin
                idx = s + b * FR * C + (1 + i) * C + C / 2;
                if (idx >= rec.size()) return 'x;
                w[31 - 8 * b - 7 + i] = rec[idx];
            end
        return w;
    endfunction

    logic [31:0] v3 [6] = '{32'h000000A1, 32'h0000B2C3, 32'hDEADBEEF, 32'h01020304, 32'h80000001, 32'h7F7F7F7F};
    logic [31:0] v6 [6] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 32'h66666666};

    initial begin
        int          n;
        int          zeros;
        int          r;
        logic [31:0] v;
        #2;
        do_reset();

        tick(32'h12345678);
        n = 0;
        while (busy && n < 400) begin
            n++;
            tick(32'h12345678);
        end
        chk("s1_busy_cycles", n, WORD_CYC + 1);
        chk("s1_word", decode(0), 32'h12345678);

        tick(32'h5);
        drain(400);
        zeros = 0;
        repeat (500) begin
            tick(32'h5);
            if (tx !== 1'b1) zeros++;
        end
        chk("s2_quiet", zeros, 0);

        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(v3[i]);
            if (i == 4) chk("s3_no_ovf_yet", overflow, 1'b0);
        end
        chk("s3_ovf", overflow, 1'b1);
        drain(2000);
        for (int k = 0; k < 5; k++) chk("s3_word", decode(k), v3[k]);

        do_reset();
        repeat (3 + 2 * FR * C + 4 * C) tick(32'hC0FFF711);
        chk("s4_busy_mid", busy, 1'b1);
        chk("s4_tx_mid", tx, 1'b0);
        do_reset();
        tick(32'h5A5AA5C3);
        drain(400);
        chk("s4_word", decode(0), 32'h5A5AA5C3);

        do_reset();
        for (int i = 0; i < 5; i++) tick(v6[i]);
        chk("s6_ovf_before", overflow, 1'b0);
        n = 0;
        while (!(m_idle && fifo.size() == DEPTH) && n < 400) begin
            tick(v6[4]);
            n++;
        end
        chk("s6_reached_full_idle", busy, 1'b1);
        tick(v6[5]);
        chk("s6_ovf", overflow, 1'b0);
        drain(2000);
        chk("s6_first", decode(0), v6[0]);
        chk("s6_last", decode(5), v6[5]);

`ifdef A0_UART_TX_PARITY_EN
        do_reset();
        tick(32'h000000FF);
        n = 0;
        while (busy && n < 400) begin
            n++;
            tick(32'h000000FF);
        end
        chk("s5_busy_cycles", n, 4 * 44 + 1);
        chk("s5_word", decode(0), 32'h000000FF);
        for (int b = 0; b < 4; b++) chk("s5_parity", rec[2 + b * 44 + 9 * C + C / 2], 1'b0);
`endif

        do_reset();
        v = $urandom;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                repeat ($urandom_range(2, 6)) begin
                    v = $urandom;
                    tick(v);
                end
            end else begin
                if (r < 5) v = $urandom;
                else if (r < 7) v = v ^ (32'h1 << $urandom_range(0, 31));
                tick(v);
            end
        end
        drain(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/a0_uart_tx.md
A0_UART_TX -- requirements
Module: a0_uart_tx

Interface
REQ-001 Parameter WIDTH SHALL be: default 32, width of the monitored a0 word; only 32 is supported.
REQ-002 Parameter CLKS_PER_BIT SHALL be: default 868, clock cycles per UART bit; legal range 2..65535.
REQ-003 Parameter FIFO_DEPTH SHALL be: default 4, number of word entries buffered; power of two, 2..16.
REQ-004 Port clk SHALL be: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 Port rst SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-006 Port a0_in SHALL be: input, WIDTH bits, the a0 register value from the CPU core.
REQ-007 Port tx SHALL be: output, 1 bit, UART serial line, idle high.
REQ-008 Port busy SHALL be: output, 1 bit, high while a frame is in flight or the FIFO is non-empty.
REQ-009 Port overflow SHALL be: output, 1 bit, sticky flag set when a word is dropped.

Function
REQ-010 Change detect: a0_prev register SHALL capture a0_in every cycle; a push SHALL occur on the rising edge where a0_in != a0_prev.
REQ-011 A push SHALL write the current a0_in into the FIFO at that same edge.
REQ-012 If the FIFO is full and no pop occurs in the same cycle, the pushed word SHALL be dropped, the FIFO SHALL be unchanged, and overflow SHALL be set.
REQ-013 If the FIFO is full and a pop occurs in the same cycle, the push SHALL be accepted.
REQ-014 If the FIFO is empty and a push and an FSM load coincide, the FSM SHALL NOT see the new word until the following cycle; no bypass.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is present only per REQ-027.
REQ-016 IDLE: tx=1. When the FIFO is non-empty, the FSM SHALL pop one word into a shift word register, set byte index to 0, and enter START at the next edge.
REQ-017 Each word SHALL be sent as 4 bytes, most significant byte first (bits 31:24, then 23:16, 15:8, 7:0).
REQ-018 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-019 DATA SHALL send 8 bits, LSB first, each for CLKS_PER_BIT cycles.
REQ-020 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles.
REQ-021 After STOP, the FSM SHALL go to START if the byte index is less than 3, incrementing the byte index; otherwise it SHALL go to IDLE.
REQ-022 Word frames SHALL be back-to-back, with no idle cycles between bytes of one word; at least one IDLE cycle SHALL occur between words.
REQ-023 The bit counter SHALL count 0..CLKS_PER_BIT-1 and wrap; a bit transition SHALL occur on the wrap.
REQ-024 tx SHALL be driven from a register, glitch-free.
REQ-025 busy SHALL be registered and SHALL equal (state != IDLE) OR (FIFO non-empty).
REQ-026 overflow SHALL stay high until reset.

Configuration
REQ-027 With macro A0_UART_TX_PARITY_EN defined, an even-parity bit over the 8 data bits SHALL be sent in state PARITY between DATA and STOP, for CLKS_PER_BIT cycles, giving an 11-bit frame. Without the macro, the PARITY state and its logic SHALL be absent, giving a 10-bit frame.

Reset
REQ-028 Asserting rst low SHALL immediately set the following: tx=1, busy=0, overflow=0, FSM=IDLE, FIFO empty, a0_prev=0, all counters 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame, with tx high immediately; the buffered words SHALL be lost.
REQ-030 After rst deasserts, a nonzero a0_in SHALL be treated as a change from 0 and pushed.

Verification (CLKS_PER_BIT=4, parity off unless stated)
REQ-031 Scenario 1: a0_in 0 to 0x12345678 after reset -> tx sends bytes 0x12, 0x34, 0x56, 0x78 with start/stop framing; the word takes 160 cycles; busy falls afterwards.
REQ-032 Scenario 2: a0_in held constant at 0x5 for 500 cycles after one transmission -> no further frames; tx stays 1.
REQ-033 Scenario 3: six distinct a0 values on consecutive cycles while idle, FIFO_DEPTH=4 -> the first is popped, the next four are buffered, the sixth is dropped and overflow=1; five words are transmitted in order.
REQ-034 Scenario 4: rst pulsed low during the DATA bit 3 of byte 2 -> tx=1 and busy=0 asynchronously; the next a0 change transmits cleanly.
REQ-035 Scenario 5: with A0_UART_TX_PARITY_EN, a0_in=0x000000FF -> data bytes 0x00, 0x00, 0x00, 0xFF with parity bits 0, 0, 0, 0; each frame is 44 cycles.
REQ-036 Scenario 6: FIFO full while the FSM pops in the same cycle as a new change -> the word is accepted and overflow stays 0.
